// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared definitions for the byte-serial memory controller.
//   - mem_state_t : controller state encoding (MEM_IDLE/MEM_IFETCH/MEM_DREAD/MEM_DWRITE)
//   - LEN_*       : data_len encodings (11 behaves as a word)
//   - ZERO32/TRUE/FALSE : common constants
//   - len_to_count: access length code -> number of byte transfers (1/2/4)
package mem_ctrl_pkg;

    localparam logic [31:0] ZERO32 = 32'h0000_0000;
    localparam logic        TRUE   = 1'b1;
    localparam logic        FALSE  = 1'b0;

    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_IFETCH = 2'd1,
        MEM_DREAD  = 2'd2,
        MEM_DWRITE = 2'd3
    } mem_state_t;

    localparam logic [1:0] LEN_BYTE = 2'b00;
    localparam logic [1:0] LEN_HALF = 2'b01;
    localparam logic [1:0] LEN_WORD = 2'b10;

    function automatic logic [2:0] len_to_count(input logic [1:0] len);
        case (len)
            LEN_BYTE: return 3'd1;
            LEN_HALF: return 3'd2;
            default:  return 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: bundles the fetch port, the load/store port and the byte-wide
// RAM port of mem_ctrl.
//   modport slave  : the controller side
//   modport master : the environment side (core stages + RAM)
// Handshake: inst_req/data_req are levels held by the requester until it sees
// the matching one-cycle done pulse; the requester drops req in the done
// cycle. Request fields must be stable while req is high and are latched on
// acceptance. dbg_state exposes the controller FSM state.
// Optional: MEM_CTRL_IO_STALL_EN adds io_buffer_full.
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    logic        inst_req;
    logic [31:0] inst_addr_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc;
    logic        inst_done;

    logic        data_req;
    logic        data_we;
    logic [1:0]  data_len;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata;
    logic [31:0] data_rdata;
    logic        data_done;

    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;

`ifdef MEM_CTRL_IO_STALL_EN
    logic        io_buffer_full;
`endif

    mem_state_t  dbg_state;

    modport slave (
        input  inst_req, inst_addr_i,
        input  data_req, data_we, data_len, data_addr_i, data_wdata,
        input  mem_din,
`ifdef MEM_CTRL_IO_STALL_EN
        input  io_buffer_full,
`endif
        output inst_o, inst_pc, inst_done,
        output data_rdata, data_done,
        output mem_dout, mem_a, mem_wr,
        output dbg_state
    );

    modport master (
        output inst_req, inst_addr_i,
        output data_req, data_we, data_len, data_addr_i, data_wdata,
        output mem_din,
`ifdef MEM_CTRL_IO_STALL_EN
        output io_buffer_full,
`endif
        input  inst_o, inst_pc, inst_done,
        input  data_rdata, data_done,
        input  mem_dout, mem_a, mem_wr,
        input  dbg_state
    );

endinterface

// File: rtl/mem_ctrl.sv
// mem_ctrl: serializes instruction fetches and byte/half/word loads/stores
// into little-endian byte transfers on an 8-bit RAM port.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mem_ctrl_if.slave (fetch port, load/store port, RAM port, dbg_state)
// Data requests win over fetches; a running transaction is never preempted.
// Reads: address for byte k in cycle k+1, byte arrives cycle k+2, done in
// cycle N+2. Writes: byte k in cycle k+1, done in cycle N+1.
// Build option MEM_CTRL_IO_STALL_EN: stores to the I/O window
// (data_addr_i[17:16] == 2'b11) are held off while io_buffer_full is high.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    mem_ctrl_if.slave bus
);

    mem_state_t  state;
    logic [2:0]  cnt;
    logic [2:0]  n_bytes;
    logic [31:0] base;
    logic [31:0] wbuf;
    logic [31:0] asm_q;
    logic [31:0] inst_o_q;
    logic [31:0] inst_pc_q;
    logic        inst_done_q;
    logic [31:0] data_rdata_q;
    logic        data_done_q;

    logic [31:0] cur_addr;
    logic        in_xfer;
    logic [7:0]  dout_byte;
    logic [31:0] asm_next;
    logic        io_stall;
    logic        accept_ok;

    // RAM-side signals are decoded from registered state only, so reset
    // forces them to zero immediately without waiting for an edge.
    always_comb begin
        cur_addr = base + {29'd0, cnt};
        in_xfer  = (state != MEM_IDLE) && (cnt < n_bytes);

        dout_byte = 8'h00;
        case (cnt)
            3'd0:    dout_byte = wbuf[7:0];
            3'd1:    dout_byte = wbuf[15:8];
            3'd2:    dout_byte = wbuf[23:16];
            3'd3:    dout_byte = wbuf[31:24];
            default: dout_byte = 8'h00;
        endcase

        // mem_din holds the byte addressed one cycle earlier, i.e. lane cnt-1.
        asm_next = asm_q;
        case (cnt)
            3'd1:    asm_next[7:0]   = bus.mem_din;
            3'd2:    asm_next[15:8]  = bus.mem_din;
            3'd3:    asm_next[23:16] = bus.mem_din;
            3'd4:    asm_next[31:24] = bus.mem_din;
            default: asm_next = asm_q;
        endcase

`ifdef MEM_CTRL_IO_STALL_EN
        io_stall = bus.data_we && (bus.data_addr_i[17:16] == 2'b11) && bus.io_buffer_full;
`else
        io_stall = FALSE;
`endif
        // Nothing is accepted in a done cycle: the requester is dropping req.
        accept_ok = !inst_done_q && !data_done_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= MEM_IDLE;
            cnt          <= 3'd0;
            n_bytes      <= 3'd0;
            base         <= ZERO32;
            wbuf         <= ZERO32;
            asm_q        <= ZERO32;
            inst_o_q     <= ZERO32;
            inst_pc_q    <= ZERO32;
            inst_done_q  <= FALSE;
            data_rdata_q <= ZERO32;
            data_done_q  <= FALSE;
        end else begin
            inst_done_q <= FALSE;
            data_done_q <= FALSE;
            case (state)
                MEM_IDLE: begin
                    cnt <= 3'd0;
                    if (accept_ok) begin
                        if (bus.data_req && !io_stall) begin
                            base    <= bus.data_addr_i;
                            n_bytes <= len_to_count(bus.data_len);
                            wbuf    <= bus.data_wdata;
                            asm_q   <= ZERO32;
                            state   <= bus.data_we ? MEM_DWRITE : MEM_DREAD;
                        end else if (bus.inst_req) begin
                            base    <= bus.inst_addr_i;
                            n_bytes <= 3'd4;
                            asm_q   <= ZERO32;
                            state   <= MEM_IFETCH;
                        end
                    end
                end
                MEM_IFETCH, MEM_DREAD: begin
                    asm_q <= asm_next;
                    if (cnt == n_bytes) begin
                        state <= MEM_IDLE;
                        cnt   <= 3'd0;
                        if (state == MEM_IFETCH) begin
                            inst_o_q    <= asm_next;
                            inst_pc_q   <= base;
                            inst_done_q <= TRUE;
                        end else begin
                            data_rdata_q <= asm_next;
                            data_done_q  <= TRUE;
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                MEM_DWRITE: begin
                    if (cnt == n_bytes - 3'd1) begin
                        state       <= MEM_IDLE;
                        cnt         <= 3'd0;
                        data_done_q <= TRUE;
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                default: begin
                    state <= MEM_IDLE;
                    cnt   <= 3'd0;
                end
            endcase
        end
    end

    assign bus.mem_a      = in_xfer ? cur_addr : ZERO32;
    assign bus.mem_wr     = in_xfer && (state == MEM_DWRITE);
    assign bus.mem_dout   = (in_xfer && (state == MEM_DWRITE)) ? dout_byte : 8'h00;
    assign bus.inst_o     = inst_o_q;
    assign bus.inst_pc    = inst_pc_q;
    assign bus.inst_done  = inst_done_q;
    assign bus.data_rdata = data_rdata_q;
    assign bus.data_done  = data_done_q;
    assign bus.dbg_state  = state;

endmodule
